// File: rtl/bus_pkg.sv
// Shared definitions for the bit-serial bus slave front end: FSM state
// encoding, transfer-mode constants and default field widths.
package bus_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 12;
    localparam int DEFAULT_DATA_WIDTH = 8;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_ADDR  = 3'd1;
    localparam state_t S_WDATA = 3'd2;
    localparam state_t S_MEMWR = 3'd3;
    localparam state_t S_MEMRD = 3'd4;
    localparam state_t S_RWAIT = 3'd5;
    localparam state_t S_RDATA = 3'd6;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Right-shifting register used for both directions of the serial link.
// Parallel load wins over shift; shifting moves shift_in into the MSB so
// an LSB-first stream ends up in natural bit order, and q[0] is the next
// bit to leave on an LSB-first output.
module serial_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             shift_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_shift;

    if (WIDTH == 1) begin : g_single
        assign q_shift = shift_in;
    end else begin : g_multi
        assign q_shift = {shift_in, q[WIDTH-1:1]};
    end

    // Register update: load, else shift, else hold.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift_en) begin
            q <= q_shift;
        end
    end

endmodule

// File: rtl/bus_slave_bram_if.sv
// Bit-serial bus slave in front of a single-port block RAM.
//
// Handshake: sready is high only in IDLE. A frame starts on the first
// cycle with mvalid=1 while sready=1; mvalid must then stay high for every
// serial bit of the frame (address, plus data for writes), otherwise the
// frame is dropped silently. On reads svalid qualifies srdata, one bit per
// cycle LSB first; there is no back-pressure on the read stream.
//
// The last serial bit is taken straight from swdata together with the
// bits already shifted in, so the RAM access starts on the next cycle.
module bus_slave_bram_if
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int MEM_DEPTH    = 4096,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  mvalid,
    input  logic                  smode,
    input  logic                  swdata,
    output logic                  sready,
    output logic                  srdata,
    output logic                  svalid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wren,
    output logic                  mem_rden,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output state_t                dbg_state
);

    localparam int RXW = max_int(ADDR_WIDTH, DATA_WIDTH);
    localparam int CW  = $clog2(RXW) + 1;
    localparam int AW1 = ADDR_WIDTH + 1;

    localparam logic [CW-1:0]  ADDR_LAST  = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0]  DATA_LAST  = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0]  RWAIT_LAST = CW'(READ_LATENCY - 1);
    localparam logic [AW1-1:0] DEPTH_LIM  = AW1'(MEM_DEPTH);

    state_t                state;
    logic [CW-1:0]         cnt;
    logic                  mode_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  range_ok;

    logic [RXW-2:0]        rx_q;
    logic [RXW-1:0]        rx_next;
    logic [ADDR_WIDTH-1:0] addr_full;
    logic [DATA_WIDTH-1:0] data_full;
    logic                  frame_bit;
    logic                  cur_mode;
    logic                  addr_last;

    logic [DATA_WIDTH-1:0] tx_q;
    logic [DATA_WIDTH-1:0] tx_load_data;
    logic                  tx_load;
    logic                  tx_shift;
    logic                  tx_upper_unused;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < DEPTH_LIM);
    endfunction

    // A serial bit is consumed on every frame cycle (start, address, data).
    assign frame_bit = mvalid && (state == S_IDLE || state == S_ADDR || state == S_WDATA);

    // Word as it will look once the current swdata bit is shifted in.
    assign rx_next   = {swdata, rx_q};
    assign addr_full = rx_next[RXW-1 -: ADDR_WIDTH];
    assign data_full = rx_next[RXW-1 -: DATA_WIDTH];

    // Mode is only valid on the first frame cycle; afterwards use the latch.
    assign cur_mode  = (state == S_IDLE) ? smode : mode_q;
    assign addr_last = (state == S_IDLE) ? (ADDR_WIDTH == 1) : (cnt == ADDR_LAST);

    serial_shift_reg #(.WIDTH(RXW - 1)) u_rx_sr (
        .clk       (clk),
        .rstn      (rstn),
        .load      (1'b0),
        .load_data ('0),
        .shift_en  (frame_bit),
        .shift_in  (swdata),
        .q         (rx_q)
    );

    // Read word capture on the final wait cycle; out-of-range reads return 0.
    assign tx_load      = (state == S_RWAIT) && (cnt == RWAIT_LAST);
    assign tx_load_data = range_ok ? mem_rdata : '0;
    assign tx_shift     = (state == S_RDATA);

    serial_shift_reg #(.WIDTH(DATA_WIDTH)) u_tx_sr (
        .clk       (clk),
        .rstn      (rstn),
        .load      (tx_load),
        .load_data (tx_load_data),
        .shift_en  (tx_shift),
        .shift_in  (1'b0),
        .q         (tx_q)
    );

    // Upper tx bits only travel down the shift chain toward bit 0.
    assign tx_upper_unused = ^tx_q[DATA_WIDTH-1:1];

    assign sready    = (state == S_IDLE);
    assign svalid    = (state == S_RDATA);
    assign srdata    = svalid & tx_q[0];
    assign dbg_state = state;

    // Frame sequencing, RAM strobes and registered RAM address/data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            mode_q    <= MODE_READ;
            addr_q    <= '0;
            range_ok  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wren  <= 1'b0;
            mem_rden  <= 1'b0;
        end else begin
            mem_wren <= 1'b0;
            mem_rden <= 1'b0;
            case (state)
                S_IDLE, S_ADDR: begin
                    if (!mvalid) begin
                        state <= S_IDLE;
                    end else begin
                        if (state == S_IDLE) begin
                            mode_q <= smode;
                        end
                        if (addr_last) begin
                            if (cur_mode == MODE_WRITE) begin
                                addr_q <= addr_full;
                                cnt    <= '0;
                                state  <= S_WDATA;
                            end else begin
                                mem_addr <= addr_full;
                                mem_rden <= in_range(addr_full);
                                range_ok <= in_range(addr_full);
                                state    <= S_MEMRD;
                            end
                        end else begin
                            cnt   <= (state == S_IDLE) ? CW'(1) : cnt + CW'(1);
                            state <= S_ADDR;
                        end
                    end
                end
                S_WDATA: begin
                    if (!mvalid) begin
                        state <= S_IDLE;
                    end else if (cnt == DATA_LAST) begin
                        mem_addr  <= addr_q;
                        mem_wdata <= data_full;
                        mem_wren  <= in_range(addr_q);
                        state     <= S_MEMWR;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_MEMWR: begin
                    state <= S_IDLE;
                end
                S_MEMRD: begin
                    cnt   <= '0;
                    state <= S_RWAIT;
                end
                S_RWAIT: begin
                    if (cnt == RWAIT_LAST) begin
                        cnt   <= '0;
                        state <= S_RDATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RDATA: begin
                    if (cnt == DATA_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_slave_bram_if.sv
// Directed bench for bus_slave_bram_if. Two instances share a clock and
// reset: dut0 has MEM_DEPTH=1000 / READ_LATENCY=1, dut1 has the full 4096
// words and READ_LATENCY=2. Each has its own behavioural RAM.
module tb_bus_slave_bram_if;
    import bus_pkg::*;

    localparam int AW = 12;
    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic [1:0]    mvalid, smode, swdata;
    logic [1:0]    sready, srdata, svalid, mem_wren, mem_rden;
    logic [AW-1:0] mem_addr  [2];
    logic [DW-1:0] mem_wdata [2];
    logic [DW-1:0] mem_rdata [2] = '{default: '0};
    state_t        dbg_state [2];

    bus_slave_bram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(1000), .READ_LATENCY(1)) dut0 (
        .clk(clk), .rstn(rstn), .mvalid(mvalid[0]), .smode(smode[0]), .swdata(swdata[0]),
        .sready(sready[0]), .srdata(srdata[0]), .svalid(svalid[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_wren(mem_wren[0]),
        .mem_rden(mem_rden[0]), .mem_rdata(mem_rdata[0]), .dbg_state(dbg_state[0])
    );

    bus_slave_bram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(4096), .READ_LATENCY(2)) dut1 (
        .clk(clk), .rstn(rstn), .mvalid(mvalid[1]), .smode(smode[1]), .swdata(swdata[1]),
        .sready(sready[1]), .srdata(srdata[1]), .svalid(svalid[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_wren(mem_wren[1]),
        .mem_rden(mem_rden[1]), .mem_rdata(mem_rdata[1]), .dbg_state(dbg_state[1])
    );

    // ---------------- RAM models (registered q, 1 and 2 cycles) ----------------
    logic [DW-1:0] ram0 [4096] = '{default: '0};
    logic [DW-1:0] ram1 [4096] = '{default: '0};
    logic [DW-1:0] q1_stage = '0;

    always @(posedge clk) begin
        if (mem_wren[0]) ram0[mem_addr[0]] <= mem_wdata[0];
        if (mem_rden[0]) mem_rdata[0] <= ram0[mem_addr[0]];
        if (mem_wren[1]) ram1[mem_addr[1]] <= mem_wdata[1];
        if (mem_rden[1]) q1_stage <= ram1[mem_addr[1]];
        mem_rdata[1] <= q1_stage;
    end

    // ---------------- bus monitor ----------------
    int            wren_cnt [2], wren_cyc [2], rden_cnt [2], rden_cyc [2];
    int            sv_cnt [2], sv_first [2];
    logic [AW-1:0] wren_addr [2], rden_addr [2];
    logic [DW-1:0] wren_data [2], sv_word [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_wren[d]) begin
                wren_cnt[d]  = wren_cnt[d] + 1;
                wren_cyc[d]  = cyc;
                wren_addr[d] = mem_addr[d];
                wren_data[d] = mem_wdata[d];
            end
            if (mem_rden[d]) begin
                rden_cnt[d]  = rden_cnt[d] + 1;
                rden_cyc[d]  = cyc;
                rden_addr[d] = mem_addr[d];
            end
            if (svalid[d]) begin
                if (sv_cnt[d] == 0) sv_first[d] = cyc;
                if (sv_cnt[d] < DW) sv_word[d][sv_cnt[d]] = srdata[d];
                sv_cnt[d] = sv_cnt[d] + 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q [$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic clear_logs(input int d);
        wren_cnt[d] = 0; wren_cyc[d] = -1; wren_addr[d] = '0; wren_data[d] = '0;
        rden_cnt[d] = 0; rden_cyc[d] = -1; rden_addr[d] = '0;
        sv_cnt[d]   = 0; sv_first[d] = -1; sv_word[d]   = '0;
    endtask

    // Sends nbits of {data, addr} LSB first; returns at the cycle after the
    // last bit (T+1) with mvalid dropped. smode is inverted after the first
    // bit since only the first cycle may matter.
    task automatic drive_frame(input int d, input logic mode, input logic [AW-1:0] a,
                               input logic [DW-1:0] v, input int nbits, output int t_last);
        logic [AW+DW-1:0] bits;
        bits   = {v, a};
        t_last = -1;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            mvalid[d] = 1'b1;
            smode[d]  = (i == 0) ? mode : ~mode;
            swdata[d] = bits[i];
            t_last    = cyc;
        end
        @(negedge clk);
        mvalid[d] = 1'b0;
        smode[d]  = 1'b0;
        swdata[d] = 1'b0;
    endtask

    task automatic do_write(input int d, input logic [AW-1:0] a, input logic [DW-1:0] v,
                            input int exp_pulses, input string tag);
        int t;
        clear_logs(d);
        drive_frame(d, MODE_WRITE, a, v, AW + DW, t);
        check_eq({tag, "_sready_busy"}, sready[d], 0);
        wait_cyc(t + 2);
        check_eq({tag, "_sready_back"}, sready[d], 1);
        wait_cyc(t + 4);
        check_eq({tag, "_wren_pulses"}, wren_cnt[d], exp_pulses);
        check_eq({tag, "_no_rden"}, rden_cnt[d], 0);
        if (exp_pulses != 0) begin
            check_eq({tag, "_wren_cycle"}, wren_cyc[d], t + 1);
            check_eq({tag, "_wren_addr"}, wren_addr[d], a);
            check_eq({tag, "_wren_data"}, wren_data[d], v);
        end
    endtask

    task automatic do_read(input int d, input logic [AW-1:0] a, input logic [DW-1:0] exp_word,
                           input int exp_pulses, input int rl, input string tag);
        int t;
        logic [DW-1:0] exp_v;
        clear_logs(d);
        exp_q.push_back(exp_word);
        drive_frame(d, MODE_READ, a, '0, AW, t);
        wait_cyc(t + 1 + rl + DW);
        check_eq({tag, "_sready_last_bit"}, sready[d], 0);
        wait_cyc(t + 2 + rl + DW);
        check_eq({tag, "_sready_back"}, sready[d], 1);
        wait_cyc(t + 4 + rl + DW);
        check_eq({tag, "_rden_pulses"}, rden_cnt[d], exp_pulses);
        check_eq({tag, "_no_wren"}, wren_cnt[d], 0);
        if (exp_pulses != 0) begin
            check_eq({tag, "_rden_cycle"}, rden_cyc[d], t + 1);
            check_eq({tag, "_rden_addr"}, rden_addr[d], a);
        end
        check_eq({tag, "_svalid_first"}, sv_first[d], t + 2 + rl);
        check_eq({tag, "_svalid_len"}, sv_cnt[d], DW);
        exp_v = exp_q.pop_front();
        check_eq({tag, "_serial_word"}, sv_word[d], exp_v);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        int t;
        rstn   = 1'b0;
        mvalid = '0;
        smode  = '0;
        swdata = '0;
        clear_logs(0);
        clear_logs(1);
        repeat (2) @(negedge clk);

        // Reset values
        check_eq("rst_sready0", sready[0], 1);
        check_eq("rst_svalid0", svalid[0], 0);
        check_eq("rst_srdata0", srdata[0], 0);
        check_eq("rst_wren0", mem_wren[0], 0);
        check_eq("rst_rden0", mem_rden[0], 0);
        check_eq("rst_addr0", mem_addr[0], 0);
        check_eq("rst_wdata0", mem_wdata[0], 0);
        check_eq("rst_state0", dbg_state[0], S_IDLE);
        check_eq("rst_sready1", sready[1], 1);
        check_eq("rst_state1", dbg_state[1], S_IDLE);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Basic write and read-back (0xA5 -> serial 1,0,1,0,0,1,0,1)
        do_write(0, 12'h005, 8'hA5, 1, "wr_005");
        do_read(0, 12'h005, 8'hA5, 1, 1, "rd_005");
        check_eq("addr_hold_idle", mem_addr[0], 12'h005);

        // Depth boundary: 999 is the last valid word, 1000 is out of range
        do_write(0, 12'h3E7, 8'h5A, 1, "wr_3e7");
        do_read(0, 12'h3E7, 8'h5A, 1, 1, "rd_3e7");
        do_write(0, 12'h3E8, 8'hFF, 0, "wr_3e8_oor");
        check_eq("ram_3e8_untouched", ram0[12'h3E8], 8'h00);
        do_read(0, 12'h3E8, 8'h00, 0, 1, "rd_3e8_oor");

        // Abort after 6 address bits
        clear_logs(0);
        drive_frame(0, MODE_WRITE, 12'h001, 8'h3C, 6, t);
        check_eq("abort_sready_busy", sready[0], 0);
        wait_cyc(t + 2);
        check_eq("abort_sready_back", sready[0], 1);
        wait_cyc(t + 6);
        check_eq("abort_no_wren", wren_cnt[0], 0);
        check_eq("abort_no_rden", rden_cnt[0], 0);
        do_write(0, 12'h001, 8'h3C, 1, "wr_001_after_abort");
        do_read(0, 12'h001, 8'h3C, 1, 1, "rd_001");

        // Asynchronous reset during read bit 3
        clear_logs(0);
        drive_frame(0, MODE_READ, 12'h005, '0, AW, t);
        wait_cyc(t + 6);
        check_eq("midrst_in_rdata", svalid[0], 1);
        #1 rstn = 1'b0;
        #1;
        check_eq("midrst_svalid", svalid[0], 0);
        check_eq("midrst_sready", sready[0], 1);
        check_eq("midrst_srdata", srdata[0], 0);
        check_eq("midrst_state", dbg_state[0], S_IDLE);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        do_read(0, 12'h005, 8'hA5, 1, 1, "rd_005_after_rst");

        // READ_LATENCY=2 instance, full 4096-word range
        do_write(1, 12'h005, 8'hA5, 1, "l2_wr_005");
        do_write(1, 12'hFFF, 8'h77, 1, "l2_wr_fff");
        do_read(1, 12'h005, 8'hA5, 1, 2, "l2_rd_005");
        do_read(1, 12'hFFF, 8'h77, 1, 2, "l2_rd_fff");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
